button_shaper_array: RTL and testbench

BUTTON_SHAPER_ARRAY -- requirements
Module: button_shaper_array

---
 rtl/button_shaper_array.sv | 117 +++++++++++
 tb/tb_button_shaper_array.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_shaper_array.sv
// Per-channel debounce, single-pulse and auto-repeat shaping for active-low buttons.
// Each channel is an independent five-state FSM with its own counters.
module button_shaper_array #(
    parameter int N             = 4,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] Bin,
    input  logic [N-1:0] RepeatEn,
    output logic [N-1:0] Bout,
    output logic [N-1:0] Held,
    output logic         AnyPulse
);

    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW   = $clog2(DEB_CYCLES);
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW:0]   DELAY_M1  = (HW+1)'(REPEAT_DELAY - 1);
    localparam logic [HW:0]   PERIOD_M1 = (HW+1)'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PULSE,
        HELD,
        REL_DB
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state, state_nx;
        logic [DW-1:0] deb, deb_nx;
        logic [HW-1:0] hold, hold_nx;
        logic          rep, rep_nx;
        logic [HW:0]   hold_inc;
        logic [HW:0]   thr_m1;

        always_ff @(posedge Clock) begin
            if (Reset) begin
                state <= IDLE;
                deb   <= '0;
                hold  <= '0;
                rep   <= 1'b0;
            end else begin
                state <= state_nx;
                deb   <= deb_nx;
                hold  <= hold_nx;
                rep   <= rep_nx;
            end
        end

        // Compare one ahead so a repeat lands exactly threshold cycles after the previous pulse
        assign hold_inc = {1'b0, hold} + (HW+1)'(1);
        assign thr_m1   = rep ? PERIOD_M1 : DELAY_M1;

        always_comb begin
            state_nx = state;
            deb_nx   = deb;
            hold_nx  = hold;
            rep_nx   = rep;
            unique case (state)
                IDLE: begin
                    if (!Bin[i]) begin
                        state_nx = PRESS_DB;
                        deb_nx   = '0;
                    end
                end
                PRESS_DB: begin
                    if (Bin[i]) begin
                        state_nx = IDLE;
                    end else if (deb == DEB_LAST) begin
                        state_nx = PULSE;
                    end else begin
                        deb_nx = deb + DW'(1);
                    end
                end
                PULSE: begin
                    state_nx = HELD;
                    hold_nx  = '0;
                end
                HELD: begin
                    if (Bin[i]) begin
                        state_nx = REL_DB;
                        deb_nx   = '0;
                    end else if (RepeatEn[i] && (hold_inc >= thr_m1)) begin
                        state_nx = PULSE;
                        rep_nx   = 1'b1;
                    end else if (~&hold) begin
                        hold_nx = hold + HW'(1);
                    end
                end
                REL_DB: begin
                    if (!Bin[i]) begin
                        state_nx = HELD;
                        hold_nx  = '0;
                    end else if (deb == DEB_LAST) begin
                        state_nx = IDLE;
                        rep_nx   = 1'b0;
                    end else begin
                        deb_nx = deb + DW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        assign Bout[i] = (state == PULSE);
        assign Held[i] = (state == HELD) || (state == REL_DB);
    end

    assign AnyPulse = |Bout;

endmodule

// File: tb/tb_button_shaper_array.sv
// Bench for button_shaper_array: timestamp-based channel model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_button_shaper_array;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] Bin = '1;
    logic [N-1:0] RepeatEn = '0;
    logic [N-1:0] Bout;
    logic [N-1:0] Held;
    logic         AnyPulse;

    int compared = 0;
    int mismatched = 0;

    button_shaper_array #(
        .N(N),
        .DEB_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Bin(Bin),
        .RepeatEn(RepeatEn),
        .Bout(Bout),
        .Held(Held),
        .AnyPulse(AnyPulse)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Model: debounced level, run length of qualifying samples, time the hold began
    bit pressed[N];
    bit just[N];
    bit repd[N];
    bit m_pulse[N];
    int run[N];
    int hold_start[N];
    int edge_no = 0;
    bit started = 1'b0;
    logic [N-1:0] eb, eh;

    function automatic void model_edge(int i, bit rst, bit b, bit re);
        int thr;
        m_pulse[i] = 1'b0;
        if (rst) begin
            pressed[i] = 1'b0;
            run[i] = 0;
            just[i] = 1'b0;
            repd[i] = 1'b0;
            return;
        end
        if (!pressed[i]) begin
            if (b) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == D + 1) begin
                    m_pulse[i] = 1'b1;
                    pressed[i] = 1'b1;
                    just[i] = 1'b1;
                    run[i] = 0;
                end
            end
        end else if (just[i]) begin
            just[i] = 1'b0;
            hold_start[i] = edge_no;
            run[i] = 0;
        end else if (b) begin
            run[i]++;
            if (run[i] == D + 1) begin
                pressed[i] = 1'b0;
                run[i] = 0;
                repd[i] = 1'b0;
            end
        end else if (run[i] > 0) begin
            run[i] = 0;
            hold_start[i] = edge_no;
        end else begin
            thr = repd[i] ? RP : RD;
            if (re && (edge_no - hold_start[i] >= thr - 1)) begin
                m_pulse[i] = 1'b1;
                repd[i] = 1'b1;
                just[i] = 1'b1;
            end
        end
    endfunction

    initial begin
        forever begin
            @(posedge Clock);
            edge_no++;
            for (int i = 0; i < N; i++) model_edge(i, Reset, Bin[i], RepeatEn[i]);
            if (Reset) started = 1'b1;
            #1;
            if (started) begin
                for (int i = 0; i < N; i++) begin
                    eb[i] = m_pulse[i];
                    eh[i] = pressed[i] && !m_pulse[i];
                end
                check("model_bout", Bout, eb);
                check("model_held", Held, eh);
                check("model_any", AnyPulse, |eb);
            end
        end
    end

    task automatic step(input logic [N-1:0] b, input logic [N-1:0] re, input bit rst = 1'b0);
        Bin = b;
        RepeatEn = re;
        Reset = rst;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int cnt;
        int first;
        int rep_idx[7];
        logic [39:0] seen, exp_seen;

        repeat (3) step('1, '0, 1'b1);
        check("reset_bout", Bout, 0);
        check("reset_held", Held, 0);
        check("reset_any", AnyPulse, 0);

        // single press on channel 0
        for (int k = 1; k <= 4; k++) step(4'b1110, '0);
        check("press_early", Bout, 0);
        step(4'b1110, '0);
        check("press_pulse", Bout, 4'b0001);
        check("press_any", AnyPulse, 1);
        step(4'b1110, '0);
        check("press_one_cycle", Bout, 0);
        check("press_held", Held, 4'b0001);
        cnt = 0;
        repeat (30) begin
            step(4'b1110, '0);
            cnt += int'(Bout[0]);
        end
        check("press_no_repeat", cnt, 0);
        repeat (6) step('1, '0);
        check("press_released", Held, 0);

        // short bounces on channel 1
        cnt = 0;
        repeat (5) begin
            repeat (3) begin
                step(4'b1101, '0);
                cnt += int'(Bout[1]) + int'(Held[1]);
            end
            repeat (3) begin
                step('1, '0);
                cnt += int'(Bout[1]) + int'(Held[1]);
            end
        end
        check("bounce_quiet", cnt, 0);

        // auto-repeat on channel 2
        rep_idx = '{4, 14, 19, 24, 29, 34, 39};
        exp_seen = '0;
        for (int k = 0; k < 7; k++) exp_seen[rep_idx[k]] = 1'b1;
        seen = '0;
        for (int k = 0; k < 40; k++) begin
            step(4'b1011, 4'b0100);
            seen[k] = Bout[2];
        end
        check("repeat_times", seen, exp_seen);
        repeat (6) step('1, '0);

        // release bounce on channel 3
        repeat (6) step(4'b0111, '0);
        cnt = 0;
        repeat (2) begin
            step('1, '0);
            cnt += int'(!Held[3]) + int'(Bout[3]);
        end
        repeat (10) begin
            step(4'b0111, '0);
            cnt += int'(!Held[3]) + int'(Bout[3]);
        end
        check("relbounce_held", cnt, 0);
        repeat (4) step('1, '0);
        check("relbounce_still", Held[3], 1);
        step('1, '0);
        check("relbounce_drop", Held[3], 0);

        // reset with ch0 in PULSE and ch3 in REL_DB
        repeat (6) step(4'b0111, '0);
        repeat (3) step(4'b0110, '0);
        repeat (2) step(4'b1110, '0);
        check("mid_bout", Bout, 4'b0001);
        check("mid_held", Held, 4'b1000);
        step(4'b1110, '0, 1'b1);
        check("mid_reset_bout", Bout, 0);
        check("mid_reset_held", Held, 0);
        check("mid_reset_any", AnyPulse, 0);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(4'b1110, '0);
            if (Bout[0] && first == 0) first = k;
        end
        check("reset_repulse", first, 5);
        repeat (6) step('1, '0);

        // late enable, then release coinciding with a threshold, on channel 1
        repeat (20) step(4'b1101, '0);
        step(4'b1101, 4'b0010);
        check("late_enable", Bout, 4'b0010);
        repeat (4) step(4'b1101, 4'b0010);
        step('1, 4'b0010);
        check("release_wins_bout", Bout, 0);
        check("release_wins_held", Held, 4'b0010);
        repeat (6) step('1, '0);

        // all channels at once
        repeat (4) step(4'b0000, '0);
        check("simul_early", Bout, 0);
        step(4'b0000, '0);
        check("simul_bout", Bout, 4'b1111);
        check("simul_any", AnyPulse, 1);
        step(4'b0000, '0);
        check("simul_after", Bout, 0);
        check("simul_any_after", AnyPulse, 0);
        check("simul_held", Held, 4'b1111);
        repeat (6) step('1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
